// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP responder that oversamples the JTAG pins with the system clock.
// Optional JTAG_TAP_INPUT_SYNC_EN adds a 2-flop synchronizer ahead of the pin register.
`timescale 1ns/1ps
module jtag_tap_responder #(
    parameter int                  IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VALUE = 32'h20000913,
    parameter logic [IR_WIDTH-1:0] USER_IR      = 5'h11,
    parameter int                  USER_WIDTH   = 41
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jtag_TCK,
    input  logic                  jtag_TMS,
    input  logic                  jtag_TDI,
    input  logic                  jtag_TRSTn,
    output logic                  jtag_TDO_data,
    output logic                  jtag_TDO_driven,
    input  logic [USER_WIDTH-1:0] user_rdata,
    output logic [USER_WIDTH-1:0] user_wdata,
    output logic                  user_update
);
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    // Pin vector order {TRSTn, TDI, TMS, TCK}; TRSTn idles high.
    localparam logic [3:0] PIN_RESET = 4'b1000;

    logic [3:0] pins_raw, pins_in, pins_reg;
    logic       tck_prev_reg;
    logic       tck_s, tms_s, tdi_s, trstn_s;
    logic       tck_rise, tck_fall, advance, commit;

    assign pins_raw = {jtag_TRSTn, jtag_TDI, jtag_TMS, jtag_TCK};

`ifdef JTAG_TAP_INPUT_SYNC_EN
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [1:0] chain_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) chain_reg <= {2{PIN_RESET[gi]}};
                else       chain_reg <= {chain_reg[0], pins_raw[gi]};
            end
            assign pins_in[gi] = chain_reg[1];
        end
    endgenerate
`else
    assign pins_in = pins_raw;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pins_reg     <= PIN_RESET;
            tck_prev_reg <= 1'b0;
        end else begin
            pins_reg     <= pins_in;
            tck_prev_reg <= pins_reg[0];
        end
    end

    assign tck_s    = pins_reg[0];
    assign tms_s    = pins_reg[1];
    assign tdi_s    = pins_reg[2];
    assign trstn_s  = pins_reg[3];
    assign tck_rise = tck_s & ~tck_prev_reg;
    assign tck_fall = ~tck_s & tck_prev_reg;
    // A low TRSTn overrides any coincident TCK edge.
    assign advance  = tck_rise & trstn_s;
    assign commit   = tck_fall & trstn_s;

    tap_state_t state_reg, state_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= TEST_LOGIC_RESET;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!trstn_s) begin
            state_next = TEST_LOGIC_RESET;
        end else if (tck_rise) begin
            case (state_reg)
                TEST_LOGIC_RESET: state_next = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        state_next = tms_s ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       state_next = tms_s ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:         state_next = tms_s ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:         state_next = tms_s ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         state_next = tms_s ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:         state_next = tms_s ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        state_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        state_next = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_next = tms_s ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:         state_next = tms_s ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:         state_next = tms_s ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         state_next = tms_s ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:         state_next = tms_s ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        state_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
                default:          state_next = TEST_LOGIC_RESET;
            endcase
        end
    end

    logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, ir_path;

    always_comb begin
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        ir_path    = 1'b0;
        case (state_reg)
            CAPTURE_DR: capture_dr = 1'b1;
            SHIFT_DR:   shift_dr   = 1'b1;
            UPDATE_DR:  update_dr  = 1'b1;
            CAPTURE_IR: begin capture_ir = 1'b1; ir_path = 1'b1; end
            SHIFT_IR:   begin shift_ir   = 1'b1; ir_path = 1'b1; end
            UPDATE_IR:  begin update_ir  = 1'b1; ir_path = 1'b1; end
            SELECT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR: ir_path = 1'b1;
            default: ;
        endcase
    end

    logic [IR_WIDTH-1:0]   ir_reg, ir_shift_reg;
    logic [31:0]           idcode_shift_reg;
    logic [USER_WIDTH-1:0] user_shift_reg, user_wdata_reg;
    logic                  bypass_reg, user_update_reg, tdo_data_reg, tdo_driven_reg;
    logic                  sel_idcode, sel_user, tdo_bit;

    assign sel_idcode = (ir_reg == IR_IDCODE);
    assign sel_user   = !sel_idcode && (ir_reg == USER_IR);
    assign tdo_bit    = ir_path    ? ir_shift_reg[0] :
                        sel_idcode ? idcode_shift_reg[0] :
                        sel_user   ? user_shift_reg[0] : bypass_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_reg           <= IR_IDCODE;
            ir_shift_reg     <= '0;
            idcode_shift_reg <= '0;
            user_shift_reg   <= '0;
            bypass_reg       <= 1'b0;
            user_wdata_reg   <= '0;
            user_update_reg  <= 1'b0;
            tdo_data_reg     <= 1'b0;
            tdo_driven_reg   <= 1'b0;
        end else begin
            user_update_reg <= 1'b0;
            if (advance) begin
                if (capture_ir) ir_shift_reg <= IR_IDCODE;
                if (shift_ir)   ir_shift_reg <= {tdi_s, ir_shift_reg[IR_WIDTH-1:1]};
                if (capture_dr) begin
                    if (sel_idcode)    idcode_shift_reg <= IDCODE_VALUE;
                    else if (sel_user) user_shift_reg   <= user_rdata;
                    else               bypass_reg       <= 1'b0;
                end
                if (shift_dr) begin
                    if (sel_idcode)    idcode_shift_reg <= {tdi_s, idcode_shift_reg[31:1]};
                    else if (sel_user) user_shift_reg   <= {tdi_s, user_shift_reg[USER_WIDTH-1:1]};
                    else               bypass_reg       <= tdi_s;
                end
            end
            // Updates land on the TCK fall inside the Update state.
            if (commit) begin
                if (update_ir) ir_reg <= ir_shift_reg;
                if (update_dr && sel_user) begin
                    user_wdata_reg  <= user_shift_reg;
                    user_update_reg <= 1'b1;
                end
            end
            if (state_next == TEST_LOGIC_RESET) ir_reg <= IR_IDCODE;
            if (tck_fall) begin
                tdo_data_reg   <= tdo_bit;
                tdo_driven_reg <= shift_ir | shift_dr;
            end
        end
    end

    assign jtag_TDO_data   = tdo_data_reg;
    assign jtag_TDO_driven = tdo_driven_reg;
    assign user_wdata      = user_wdata_reg;
    assign user_update     = user_update_reg;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// Randomized bench for jtag_tap_responder against a scan-level queue model of the TAP.
`timescale 1ns/1ps
module tb_jtag_tap_responder;
    localparam int          IR_W       = 5;
    localparam int          USER_W     = 41;
    localparam logic [31:0] IDCODE     = 32'h20000913;
    localparam logic [4:0]  USER_INSTR = 5'h11;

    logic              clock = 1'b0;
    logic              reset;
    logic              jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic              jtag_TDO_data, jtag_TDO_driven;
    logic [USER_W-1:0] user_rdata, user_wdata;
    logic              user_update;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;
    int model_upd;
    logic [4:0]        model_ir;
    logic [USER_W-1:0] model_wdata;

    jtag_tap_responder dut (
        .clock(clock), .reset(reset),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
        .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
        .user_rdata(user_rdata), .user_wdata(user_wdata), .user_update(user_update)
    );

    always #5 clock = ~clock;

    // Counts high cycles, so a stretched pulse shows up as an extra count.
    always @(posedge clock) if (user_update === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One TCK period; returns TDO/driven as seen just before the rising edge.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic drv);
        int h;
        h = 5 + int'($urandom_range(0, 3));
        tdo = jtag_TDO_data;
        drv = jtag_TDO_driven;
        jtag_TMS = tms;
        jtag_TDI = tdi;
        wait_clks(h);
        jtag_TCK = 1'b1;
        wait_clks(h);
        jtag_TCK = 1'b0;
        wait_clks(h);
    endtask

    task automatic tms_step(input logic tms);
        logic a, b;
        tck_cycle(tms, 1'b0, a, b);
    endtask

    function automatic int dr_width(input logic [4:0] ir);
        if (ir == 5'd1) return 32;
        if (ir == USER_INSTR) return USER_W;
        return 1;
    endfunction

    function automatic logic [63:0] dr_capture(input logic [4:0] ir);
        if (ir == 5'd1) return {32'b0, IDCODE};
        if (ir == USER_INSTR) return {23'b0, user_rdata};
        return 64'd0;
    endfunction

    // Full scan from Run-Test/Idle back to Run-Test/Idle, optionally pausing after bit pause_at.
    task automatic scan(input bit is_ir, input logic [63:0] din, input int nbits,
                        input int pause_at, input string tag, output logic [63:0] dout);
        bit q[$];
        logic tdo, drv;
        int w;
        logic [63:0] cap, v;
        if (is_ir) begin w = IR_W; cap = 64'd1; end
        else begin w = dr_width(model_ir); cap = dr_capture(model_ir); end
        for (int i = 0; i < w; i++) q.push_back(cap[i]);
        dout = 64'd0;
        tms_step(1'b1);
        if (is_ir) tms_step(1'b1);
        tms_step(1'b0);
        tms_step(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bit last, pz, exp_bit;
            last = (i == nbits - 1);
            pz   = (i == pause_at) && !last;
            tck_cycle(last || pz, din[i], tdo, drv);
            exp_bit = q.pop_front();
            q.push_back(din[i]);
            check({tag, " tdo"}, 64'(tdo), 64'(exp_bit));
            check({tag, " driven"}, 64'(drv), 64'd1);
            dout[i] = tdo;
            if (pz) begin
                tms_step(1'b0);
                check({tag, " pause driven"}, 64'(jtag_TDO_driven), 64'd0);
                repeat ($urandom_range(1, 4)) tms_step(1'b0);
                tms_step(1'b1);
                tms_step(1'b0);
            end
        end
        check({tag, " exit driven"}, 64'(jtag_TDO_driven), 64'd0);
        tms_step(1'b1);
        tms_step(1'b0);
        v = 64'd0;
        for (int i = 0; i < w; i++) v[i] = q[i];
        if (is_ir) model_ir = v[4:0];
        else if (model_ir == USER_INSTR) begin
            model_wdata = v[USER_W-1:0];
            model_upd++;
        end
    endtask

    task automatic enter_shift_dr();
        tms_step(1'b1);
        tms_step(1'b0);
        tms_step(1'b0);
    endtask

    task automatic check_user(input string tag);
        check({tag, " upd_cnt"}, 64'(upd_cnt), 64'(model_upd));
        check({tag, " wdata"}, 64'(user_wdata), 64'(model_wdata));
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] dout, r;
        logic [USER_W-1:0] rd_copy;
        logic a, b;
        reset = 1'b1; jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
        user_rdata = '0; model_ir = 5'd1; model_wdata = '0; model_upd = 0;
        wait_clks(3);
        check("reset tdo", 64'(jtag_TDO_data), 64'd0);
        check("reset driven", 64'(jtag_TDO_driven), 64'd0);
        check("reset wdata", 64'(user_wdata), 64'd0);
        check("reset update", 64'(user_update), 64'd0);
        reset = 1'b0;
        wait_clks(6);
        tms_step(1'b0);

        scan(1'b0, 64'd0, 32, -1, "idcode", dout);
        check("idcode word", dout, {32'b0, IDCODE});

        scan(1'b1, 64'h11, 5, -1, "ir capture", dout);
        check("ir capture word", dout, 64'h01);

        r = {$urandom(), $urandom()};
        user_rdata = r[USER_W-1:0];
        rd_copy = user_rdata;
        scan(1'b0, 64'h12_3456_789A, USER_W, -1, "user", dout);
        check("user tdo word", dout, 64'(rd_copy));
        check("user wdata const", 64'(user_wdata), 64'h12_3456_789A);
        check("user pulses", 64'(upd_cnt), 64'd1);

        scan(1'b1, 64'h1F, 5, -1, "ir bypass", dout);
        scan(1'b0, 64'b1101, 4, -1, "bypass", dout);
        check("bypass word", dout, 64'b1010);

        // Five TMS=1 clocks from Shift-DR must land in Test-Logic-Reset.
        enter_shift_dr();
        repeat (5) tms_step(1'b1);
        model_ir = 5'd1;
        check_user("tms reset");
        tms_step(1'b0);
        scan(1'b0, 64'd0, 32, -1, "after tms reset", dout);
        check("after tms reset idcode", dout, {32'b0, IDCODE});

        // TRSTn pulse coinciding with a TCK rise inside Shift-DR of the USER register.
        scan(1'b1, 64'(USER_INSTR), 5, -1, "ir user2", dout);
        enter_shift_dr();
        repeat (3) tck_cycle(1'b0, 1'b1, a, b);
        jtag_TMS = 1'b0;
        wait_clks(6);
        jtag_TRSTn = 1'b0;
        jtag_TCK = 1'b1;
        wait_clks(1);
        jtag_TRSTn = 1'b1;
        wait_clks(6);
        jtag_TCK = 1'b0;
        wait_clks(8);
        model_ir = 5'd1;
        check("trst driven", 64'(jtag_TDO_driven), 64'd0);
        check_user("trst");
        tms_step(1'b0);
        scan(1'b0, 64'd0, 32, -1, "after trst", dout);
        check("after trst idcode", dout, {32'b0, IDCODE});

        // Asynchronous reset in the middle of a USER shift.
        scan(1'b1, 64'(USER_INSTR), 5, -1, "ir user3", dout);
        enter_shift_dr();
        repeat (10) tck_cycle(1'b0, 1'($urandom()), a, b);
        reset = 1'b1;
        wait_clks(2);
        check("midreset tdo", 64'(jtag_TDO_data), 64'd0);
        check("midreset driven", 64'(jtag_TDO_driven), 64'd0);
        reset = 1'b0;
        wait_clks(4);
        model_ir = 5'd1;
        model_wdata = '0;
        check("midreset wdata", 64'(user_wdata), 64'd0);
        check_user("midreset");
        tms_step(1'b0);
        scan(1'b0, 64'd0, 32, -1, "after reset", dout);
        check("after reset idcode", dout, {32'b0, IDCODE});

        for (int it = 0; it < 15; it++) begin
            logic [4:0] ir_pick;
            int n;
            case ($urandom_range(0, 3))
                0:       ir_pick = 5'd1;
                1:       ir_pick = USER_INSTR;
                2:       ir_pick = 5'h1F;
                default: ir_pick = 5'($urandom());
            endcase
            repeat ($urandom_range(0, 2)) tms_step(1'b0);
            scan(1'b1, {59'b0, ir_pick}, 5, int'($urandom_range(0, 5)), "rand ir", dout);
            check("rand ir capture", dout, 64'd1);
            r = {$urandom(), $urandom()};
            user_rdata = r[USER_W-1:0];
            r = {$urandom(), $urandom()};
            n = dr_width(model_ir) + int'($urandom_range(0, 3));
            scan(1'b0, r, n, int'($urandom_range(0, n)), "rand dr", dout);
            check_user("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
